// File: rtl/mips_multicycle_hs.sv
// Multicycle (non-pipelined) MIPS core with valid/ready memory handshakes.
// Stages: INIT_RA -> FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK, one-hot.
// Optional retire/stall counters are built when MIPS_RETIRE_CNT_EN is defined.
module mips_multicycle_hs #(
  parameter logic [31:0] PC_INIT      = 32'h0000_0000,
  parameter logic [31:0] SP_INIT      = 32'h0000_0000,
  parameter logic [31:0] RA_INIT      = 32'h0000_0000,
  parameter int unsigned DATA_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        instr_req,
  output logic [31:0] instr_addr,
  input  logic        instr_valid,
  input  logic [31:0] instr_in,
  output logic        data_req,
  output logic        data_rd_wr,
  output logic [31:0] data_addr,
  output logic [31:0] data_out,
  input  logic        data_ready,
  input  logic [31:0] data_in,
  output logic        retire,
  output logic        illegal_instr,
  output logic        bus_error
`ifdef MIPS_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [5:0] {
    StInitRa    = 6'b000001,
    StFetch     = 6'b000010,
    StDecode    = 6'b000100,
    StExecute   = 6'b001000,
    StMemory    = 6'b010000,
    StWriteback = 6'b100000
  } state_e;

  typedef enum logic [3:0] {
    OpNop, OpAddu, OpSubu, OpAnd, OpOr, OpSlt, OpJr, OpJ, OpJal,
    OpBeq, OpBne, OpAddiu, OpSlti, OpLw, OpSw
  } op_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0] alu_q, alu_d, npc_q, npc_d, mdr_q, mdr_d, wait_q, wait_d;
  logic        bus_error_q, bus_error_d;

  logic [31:0] rf_q [32];
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  op_e         op;
  logic        illegal;
  logic [4:0]  rs_idx, rt_idx, rd_idx;
  logic [31:0] imm_sext, rs_rdata, rt_rdata, pc_plus4, br_target, alu_res, next_pc;
  logic        is_mem, timeout_hit, wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  assign rs_idx    = ir_q[25:21];
  assign rt_idx    = ir_q[20:16];
  assign rd_idx    = ir_q[15:11];
  assign imm_sext  = {{16{ir_q[15]}}, ir_q[15:0]};
  assign rs_rdata  = (rs_idx == 5'd0) ? 32'd0 : rf_q[rs_idx];
  assign rt_rdata  = (rt_idx == 5'd0) ? 32'd0 : rf_q[rt_idx];
  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
  assign is_mem    = (op == OpLw) || (op == OpSw);
  // Counter equals the limit only after DATA_TIMEOUT cycles without data_ready.
  assign timeout_hit = (DATA_TIMEOUT != 0) && (wait_q == 32'(DATA_TIMEOUT));

  assign instr_addr = pc_q;
  assign data_addr  = alu_q;
  assign data_out   = b_q;
  assign bus_error  = bus_error_q;

  // Instruction decode from the latched IR; unsupported encodings become NOP.
  always_comb begin
    op      = OpNop;
    illegal = 1'b0;
    if (ir_q[31:26] == 6'h00) begin
      case (ir_q[5:0])
        6'h00:   illegal = (ir_q != 32'h0);  // only the all-zero SLL is a NOP
        6'h08:   op = OpJr;
        6'h21:   op = OpAddu;
        6'h23:   op = OpSubu;
        6'h24:   op = OpAnd;
        6'h25:   op = OpOr;
        6'h2a:   op = OpSlt;
        default: illegal = 1'b1;
      endcase
    end else begin
      case (ir_q[31:26])
        6'h02:   op = OpJ;
        6'h03:   op = OpJal;
        6'h04:   op = OpBeq;
        6'h05:   op = OpBne;
        6'h09:   op = OpAddiu;
        6'h0a:   op = OpSlti;
        6'h23:   op = OpLw;
        6'h2b:   op = OpSw;
        default: illegal = 1'b1;
      endcase
    end
  end

  // ALU result and next-PC selection, evaluated on the DECODE-latched operands.
  always_comb begin
    alu_res = 32'd0;
    next_pc = pc_plus4;
    case (op)
      OpAddu:        alu_res = a_q + b_q;
      OpSubu:        alu_res = a_q - b_q;
      OpAnd:         alu_res = a_q & b_q;
      OpOr:          alu_res = a_q | b_q;
      OpSlt:         alu_res = ($signed(a_q) < $signed(b_q)) ? 32'd1 : 32'd0;
      OpAddiu:       alu_res = a_q + imm_sext;
      OpSlti:        alu_res = ($signed(a_q) < $signed(imm_sext)) ? 32'd1 : 32'd0;
      OpLw, OpSw:    alu_res = a_q + imm_sext;
      OpJr:          next_pc = a_q;
      OpJ:           next_pc = {pc_plus4[31:28], ir_q[25:0], 2'b00};
      OpJal: begin
        alu_res = pc_plus4;  // link value
        next_pc = {pc_plus4[31:28], ir_q[25:0], 2'b00};
      end
      OpBeq:         next_pc = (a_q == b_q) ? br_target : pc_plus4;
      OpBne:         next_pc = (a_q != b_q) ? br_target : pc_plus4;
      default:       alu_res = 32'd0;
    endcase
  end

  // Writeback destination select.
  always_comb begin
    wb_en   = 1'b0;
    wb_addr = 5'd0;
    wb_data = alu_q;
    case (op)
      OpAddu, OpSubu, OpAnd, OpOr, OpSlt: begin wb_en = 1'b1; wb_addr = rd_idx; end
      OpAddiu, OpSlti:                    begin wb_en = 1'b1; wb_addr = rt_idx; end
      OpLw:    begin wb_en = 1'b1; wb_addr = rt_idx; wb_data = mdr_q; end
      OpJal:   begin wb_en = 1'b1; wb_addr = 5'd31; end
      default: wb_en = 1'b0;
    endcase
  end

  // Stage sequencing, handshakes, regfile write port; synchronous reset overrides all.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    a_d           = a_q;
    b_d           = b_q;
    alu_d         = alu_q;
    npc_d         = npc_q;
    mdr_d         = mdr_q;
    wait_d        = wait_q;
    bus_error_d   = bus_error_q;
    rf_we         = 1'b0;
    rf_waddr      = 5'd0;
    rf_wdata      = 32'd0;
    instr_req     = 1'b0;
    data_req      = 1'b0;
    data_rd_wr    = 1'b1;
    retire        = 1'b0;
    illegal_instr = 1'b0;
    unique case (state_q)
      StInitRa: begin
        rf_we    = 1'b1;
        rf_waddr = 5'd31;
        rf_wdata = RA_INIT;
        state_d  = StFetch;
      end
      StFetch: begin
        instr_req = 1'b1;
        if (instr_valid) begin
          ir_d    = instr_in;
          state_d = StDecode;
        end
      end
      StDecode: begin
        illegal_instr = illegal;
        a_d           = rs_rdata;
        b_d           = rt_rdata;
        state_d       = StExecute;
      end
      StExecute: begin
        alu_d   = alu_res;
        npc_d   = next_pc;
        wait_d  = 32'd0;
        state_d = StMemory;
      end
      StMemory: begin
        if (is_mem) begin
          data_rd_wr = (op != OpSw);
          if (timeout_hit) begin
            bus_error_d = 1'b1;
            mdr_d       = 32'd0;
            state_d     = StWriteback;
          end else begin
            data_req = 1'b1;
            if (data_ready) begin
              mdr_d   = data_in;
              state_d = StWriteback;
            end else begin
              wait_d = wait_q + 32'd1;
            end
          end
        end else begin
          state_d = StWriteback;
        end
      end
      StWriteback: begin
        retire   = 1'b1;
        pc_d     = npc_q;
        rf_we    = wb_en && (wb_addr != 5'd0);
        rf_waddr = wb_addr;
        rf_wdata = wb_data;
        state_d  = StFetch;
      end
      default: state_d = StInitRa;
    endcase
    if (reset) begin
      state_d       = StInitRa;
      pc_d          = PC_INIT;
      wait_d        = 32'd0;
      bus_error_d   = 1'b0;
      instr_req     = 1'b0;
      data_req      = 1'b0;
      data_rd_wr    = 1'b1;
      retire        = 1'b0;
      illegal_instr = 1'b0;
      rf_we         = 1'b1;
      rf_waddr      = 5'd29;
      rf_wdata      = SP_INIT;
    end
  end

  // Pipeline-free state registers.
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    pc_q        <= pc_d;
    ir_q        <= ir_d;
    a_q         <= a_d;
    b_q         <= b_d;
    alu_q       <= alu_d;
    npc_q       <= npc_d;
    mdr_q       <= mdr_d;
    wait_q      <= wait_d;
    bus_error_q <= bus_error_d;
  end

  // Register file single write port; r0 is never written and reads as zero.
  always_ff @(posedge clk) begin
    if (rf_we) rf_q[rf_waddr] <= rf_wdata;
  end

`ifdef MIPS_RETIRE_CNT_EN
  logic [31:0] retire_count_q, retire_count_d, stall_count_q, stall_count_d;
  logic        stall;

  // Retire counter wraps; stall counter saturates at all-ones.
  always_comb begin
    stall          = ((state_q == StFetch) && !instr_valid) || (data_req && !data_ready);
    retire_count_d = retire_count_q + (retire ? 32'd1 : 32'd0);
    stall_count_d  = stall_count_q;
    if (stall && (stall_count_q != 32'hFFFF_FFFF)) stall_count_d = stall_count_q + 32'd1;
    if (reset) begin
      retire_count_d = 32'd0;
      stall_count_d  = 32'd0;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    retire_count_q <= retire_count_d;
    stall_count_q  <= stall_count_d;
  end

  assign retire_count = retire_count_q;
  assign stall_count  = stall_count_q;
`endif

endmodule

// File: tb/tb_mips_multicycle_hs.sv
// Self-checking bench for mips_multicycle_hs: directed program plus random instructions
// with random handshake delays, checked against an ISA-level reference model.
module tb_mips_multicycle_hs;
  localparam logic [31:0] PcInit  = 32'h0000_0400;
  localparam logic [31:0] SpInit  = 32'h0000_1000;
  localparam logic [31:0] RaInit  = 32'h0000_2000;
  localparam int unsigned Timeout = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_req, instr_valid, data_req, data_rd_wr, data_ready;
  logic        retire, illegal_instr, bus_error;
  logic [31:0] instr_addr, instr_in, data_addr, data_out, data_in;
`ifdef MIPS_RETIRE_CNT_EN
  logic [31:0] retire_count, stall_count;
`endif

  always #5 clk = ~clk;

  mips_multicycle_hs #(
    .PC_INIT(PcInit), .SP_INIT(SpInit), .RA_INIT(RaInit), .DATA_TIMEOUT(Timeout)
  ) dut (
    .clk(clk), .reset(reset),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_valid(instr_valid),
    .instr_in(instr_in),
    .data_req(data_req), .data_rd_wr(data_rd_wr), .data_addr(data_addr),
    .data_out(data_out), .data_ready(data_ready), .data_in(data_in),
    .retire(retire), .illegal_instr(illegal_instr), .bus_error(bus_error)
`ifdef MIPS_RETIRE_CNT_EN
    , .retire_count(retire_count), .stall_count(stall_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Architectural reference state.
  logic [31:0] regs [32];
  logic [31:0] dmem [logic [31:0]];
  logic [31:0] pc_m;
  bit          berr_m;
  int unsigned ret_m, stall_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] opc, input logic [25:0] t);
    return {opc, t};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  r1, r2, r3;
    logic [15:0] imm, woff;
    r1   = 5'($urandom);
    r2   = 5'($urandom);
    r3   = 5'($urandom);
    imm  = 16'($urandom);
    woff = 16'($urandom_range(0, 15) * 4);
    case ($urandom_range(0, 14))
      0:  return enc_r(6'h21, r1, r2, r3);
      1:  return enc_r(6'h23, r1, r2, r3);
      2:  return enc_r(6'h24, r1, r2, r3);
      3:  return enc_r(6'h25, r1, r2, r3);
      4:  return enc_r(6'h2a, r1, r2, r3);
      5:  return enc_i(6'h09, r1, r2, imm);
      6:  return enc_i(6'h0a, r1, r2, imm);
      7:  return enc_i(6'h23, 5'd0, r2, woff);
      8:  return enc_i(6'h2b, 5'd0, r2, woff);
      9:  return enc_i(6'h04, r1, ($urandom_range(0, 1) == 1) ? r1 : r2, imm);
      10: return enc_i(6'h05, r1, ($urandom_range(0, 1) == 1) ? r1 : r2, imm);
      11: return enc_j(6'h02, 26'($urandom));
      12: return enc_j(6'h03, 26'($urandom));
      13: return enc_r(6'h08, r1, 5'd0, 5'd0);
      default: begin
        case ($urandom_range(0, 2))
          0:       return enc_i(6'h3f, r1, r2, imm);
          1:       return enc_r(6'h20, r1, r2, r3);
          default: return {11'd0, r2, r3, 5'd3, 6'h00};
        endcase
      end
    endcase
  endfunction

  // Run one instruction from FETCH to the following FETCH, checking each stage.
  task automatic step(input logic [31:0] ir, input int fwait, input int mwait, input bit nordy);
    logic [5:0]  opc, fn;
    logic [4:0]  rs, rt, rd, dst;
    logic [31:0] a, b, se, pc4, npc, wval, addr, ld, word;
    bit          ill, mem, is_ld;
    opc = ir[31:26]; fn = ir[5:0]; rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11];
    a = regs[rs]; b = regs[rt]; se = {{16{ir[15]}}, ir[15:0]};
    pc4 = pc_m + 32'd4; npc = pc4;
    wval = '0; addr = '0; ld = '0; dst = '0; ill = 0; mem = 0; is_ld = 0;
    if (opc == 6'h00) begin
      case (fn)
        6'h00: ill = (ir != 32'h0);
        6'h08: npc = a;
        6'h21: begin dst = rd; wval = a + b; end
        6'h23: begin dst = rd; wval = a - b; end
        6'h24: begin dst = rd; wval = a & b; end
        6'h25: begin dst = rd; wval = a | b; end
        6'h2a: begin dst = rd; wval = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
        default: ill = 1;
      endcase
    end else begin
      case (opc)
        6'h02: npc = {pc4[31:28], ir[25:0], 2'b00};
        6'h03: begin npc = {pc4[31:28], ir[25:0], 2'b00}; dst = 5'd31; wval = pc4; end
        6'h04: if (a == b) npc = pc4 + (se << 2);
        6'h05: if (a != b) npc = pc4 + (se << 2);
        6'h09: begin dst = rt; wval = a + se; end
        6'h0a: begin dst = rt; wval = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
        6'h23: begin mem = 1; is_ld = 1; dst = rt; addr = a + se; end
        6'h2b: begin mem = 1; addr = a + se; end
        default: ill = 1;
      endcase
    end
    word = {addr[31:2], 2'b00};
    if (is_ld) begin
      if (nordy) ld = 32'd0;
      else begin
        if (!dmem.exists(word)) dmem[word] = $urandom;
        ld = dmem[word];
      end
      wval = ld;
    end

    // FETCH
    check("fetch_req", {31'd0, instr_req}, 32'd1);
    check("fetch_addr", instr_addr, pc_m);
    for (int i = 0; i < fwait; i++) begin
      instr_valid = 1'b0;
      data_ready  = 1'($urandom_range(0, 1));
      tick();
      check("fetch_hold", {31'd0, instr_req}, 32'd1);
      check("fetch_addr_stable", instr_addr, pc_m);
    end
    instr_valid = 1'b1;
    instr_in    = ir;
    data_ready  = 1'($urandom_range(0, 1));
    tick();
    // DECODE
    check("illegal", {31'd0, illegal_instr}, {31'd0, ill});
    check("dec_quiet", {29'd0, instr_req, data_req, retire}, 32'd0);
    instr_valid = 1'($urandom_range(0, 1));
    instr_in    = $urandom;
    tick();
    // EXECUTE
    check("exe_quiet", {29'd0, illegal_instr, data_req, retire}, 32'd0);
    instr_valid = 1'($urandom_range(0, 1));
    data_ready  = 1'($urandom_range(0, 1));
    tick();
    // MEMORY
    check("mem_noretire", {31'd0, retire}, 32'd0);
    data_in = $urandom;
    if (mem) begin
      check("mem_req", {31'd0, data_req}, 32'd1);
      check("mem_rw", {31'd0, data_rd_wr}, {31'd0, is_ld});
      check("mem_addr", data_addr, addr);
      if (!is_ld) check("mem_wdata", data_out, b);
      if (nordy) begin
        for (int i = 1; i <= int'(Timeout); i++) begin
          data_ready = 1'b0;
          tick();
          check("to_req", {31'd0, data_req}, (i < int'(Timeout)) ? 32'd1 : 32'd0);
        end
        stall_m += Timeout;
        berr_m = 1;
        tick();
      end else begin
        for (int i = 0; i < mwait; i++) begin
          data_ready = 1'b0;
          tick();
          check("mem_hold", {31'd0, data_req}, 32'd1);
          check("mem_addr_stable", data_addr, addr);
        end
        stall_m += mwait;
        data_ready = 1'b1;
        data_in    = ld;
        if (!is_ld) dmem[word] = b;
        tick();
      end
    end else begin
      check("mem_idle", {31'd0, data_req}, 32'd0);
      data_ready = 1'($urandom_range(0, 1));
      tick();
    end
    // WRITEBACK
    data_ready = 1'b0;
    check("retire", {31'd0, retire}, 32'd1);
    check("wb_noreq", {30'd0, instr_req, data_req}, 32'd0);
    check("bus_error", {31'd0, bus_error}, {31'd0, berr_m});
    tick();
    stall_m += fwait;
    ret_m++;
    if (dst != 5'd0) regs[dst] = wval;
    pc_m = npc;
  endtask

  task automatic rst_model();
    pc_m = PcInit; regs[29] = SpInit; regs[31] = RaInit;
    berr_m = 0; ret_m = 0; stall_m = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    instr_valid = 1'b0; instr_in = '0; data_ready = 1'b0; data_in = '0;
    rst_model();

    // Reset and INIT_RA
    tick(); tick();
    check("rst_outs", {26'd0, instr_req, data_req, data_rd_wr, retire, illegal_instr, bus_error},
          32'b001000);
    reset = 1'b0;
    #1;
    check("init_ra_outs", {29'd0, instr_req, data_req, retire}, 32'd0);
    tick();

    // Directed program
    step(enc_i(6'h2b, 5'd0, 5'd29, 16'h0), 0, 0, 0);
    step(enc_i(6'h2b, 5'd0, 5'd31, 16'h0), 0, 0, 0);
    step(enc_i(6'h09, 5'd0, 5'd8, 16'd5), 0, 0, 0);
    step(enc_i(6'h09, 5'd0, 5'd9, 16'hFFFD), 0, 0, 0);
    step(enc_r(6'h21, 5'd8, 5'd9, 5'd10), 0, 0, 0);
    step(enc_r(6'h23, 5'd9, 5'd8, 5'd11), 0, 0, 0);
    step(enc_r(6'h2a, 5'd9, 5'd8, 5'd12), 0, 0, 0);
    step(enc_i(6'h2b, 5'd0, 5'd10, 16'h0), 0, 0, 0);
    step(enc_i(6'h2b, 5'd0, 5'd11, 16'h0), 0, 0, 0);
    step(enc_i(6'h2b, 5'd0, 5'd12, 16'h0), 0, 0, 0);
    step(enc_i(6'h2b, 5'd29, 5'd10, 16'd8), 0, 3, 0);
    step(enc_i(6'h23, 5'd29, 5'd13, 16'd8), 0, 0, 0);
    step(enc_i(6'h2b, 5'd0, 5'd13, 16'h0), 0, 0, 0);
    step(enc_i(6'h04, 5'd0, 5'd0, 16'd2), 0, 0, 0);
    step(enc_i(6'h05, 5'd0, 5'd0, 16'd2), 0, 0, 0);
    step(enc_j(6'h03, 26'h010_0040), 0, 0, 0);
    step(enc_i(6'h2b, 5'd0, 5'd31, 16'h0), 0, 0, 0);
    step(enc_r(6'h08, 5'd31, 5'd0, 5'd0), 0, 0, 0);
    step(32'hFC00_0000, 0, 0, 0);
    step(32'h0000_0000, 1, 0, 0);

    // Give every register a known value, then random traffic
    for (int r = 1; r < 32; r++) step(enc_i(6'h09, 5'd0, 5'(r), 16'($urandom)), 0, 0, 0);
    for (int n = 0; n < 150; n++)
      step(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 4), 0);

    // Data timeout on a load: rt gets 0 and bus_error sticks
    step(enc_i(6'h23, 5'd0, 5'd14, 16'h20), 0, 0, 1);
    step(enc_i(6'h2b, 5'd0, 5'd14, 16'h0), 2, 1, 0);

`ifdef MIPS_RETIRE_CNT_EN
    check("retire_count", retire_count, ret_m);
    check("stall_count", stall_count, stall_m);
`endif

    // Reset in the middle of a store's MEMORY stage
    check("mr_fetch_addr", instr_addr, pc_m);
    instr_valid = 1'b1;
    instr_in    = enc_i(6'h2b, 5'd0, 5'd5, 16'h40);
    tick();
    instr_valid = 1'b0;
    tick(); tick();
    check("mr_mem_req", {31'd0, data_req}, 32'd1);
    data_ready = 1'b0;
    tick();
    reset = 1'b1;
    data_ready = 1'b1;
    instr_valid = 1'b1;
    #1;
    check("mr_req_drop", {30'd0, data_req, data_rd_wr}, 32'd1);
    tick();
    reset = 1'b0;
    data_ready = 1'b0;
    instr_valid = 1'b0;
    rst_model();
    #1;
    check("mr_init_outs", {28'd0, instr_req, data_req, retire, bus_error}, 32'd0);
`ifdef MIPS_RETIRE_CNT_EN
    check("mr_retire_count", retire_count, 32'd0);
`endif
    tick();

    // Sweep every register out through stores
    for (int r = 1; r < 32; r++) step(enc_i(6'h2b, 5'd0, 5'(r), 16'h0), $urandom_range(0, 2),
                                      $urandom_range(0, 2), 0);
`ifdef MIPS_RETIRE_CNT_EN
    check("final_retire_count", retire_count, ret_m);
    check("final_stall_count", stall_count, stall_m);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_hs.md
Name: mips_multicycle_hs

Overview:
Next-generation non-pipelined five-stage MIPS core. Stage sequencing is a one-hot FSM, as in the existing core. This block adds valid/ready handshakes on the instruction and data ports, so the core stalls on slow memories. It also adds a wider integer/branch instruction subset, an internal 32x32 register file with r0 hardwired to zero, and an illegal-instruction flag. It sits between the instruction/data memory models and the system testbench.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset.
SP_INIT, 32'h0000_0000, value written to r29 on the reset cycle.
RA_INIT, 32'h0000_0000, value written to r31 on the first cycle after reset.
DATA_TIMEOUT, 16, max data-handshake wait cycles; 0 disables the timeout.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
instr_req  out  1  instruction fetch request
instr_addr  out  32  fetch address, equals PC
instr_valid  in  1  instr_in is valid this cycle
instr_in  in  32  instruction word
data_req  out  1  data access request
data_rd_wr  out  1  1 = read, 0 = write
data_addr  out  32  byte address (ALU result)
data_out  out  32  store data (rt)
data_ready  in  1  access complete; data_in is valid for reads
data_in  in  32  load data
retire  out  1  one-cycle pulse when an instruction completes writeback
illegal_instr  out  1  one-cycle pulse during DECODE of an unsupported encoding
bus_error  out  1  sticky; set on data timeout, cleared only by reset

Behaviour:
- Reset state: FSM in INIT_RA, PC = PC_INIT.
  - Outputs: instr_req = 0, data_req = 0, data_rd_wr = 1, retire = 0, illegal_instr = 0, bus_error = 0.
  - Regfile write of r29 <= SP_INIT occurs in the reset cycle itself.
- FSM states: INIT_RA -> FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK -> FETCH. One-hot encoding.
- INIT_RA: one cycle; writes r31 <= RA_INIT; next state FETCH.
- FETCH:
  - instr_req = 1. Hold FETCH while instr_valid = 0.
  - On instr_valid = 1: latch IR, go to DECODE. instr_addr must be stable while instr_req is high.
- DECODE: read rs/rt (same-cycle regfile writes are invisible; there are none in this core). Sign-extend imm16. Generate controls.
- Supported encodings; all others decode as NOP and pulse illegal_instr:
  - SPECIAL funct: SLL (NOP only when IR == 0; nonzero SLL is illegal), JR, ADDU, SUBU, AND, OR, SLT.
  - Opcodes: J, JAL, BEQ, BNE, ADDIU, SLTI, LW, SW.
- EXECUTE: compute the ALU result; 32-bit wrap-around, no overflow trap.
  - SLT/SLTI are signed compares.
  - Next PC:
    - JR: rs
    - J/JAL: {pc_plus4[31:28], target26, 2'b00}
    - BEQ/BNE taken: pc_plus4 + (sext(imm) << 2)
    - Otherwise: pc_plus4
  - pc_plus4 = PC + 4 computed on the fetched PC. No branch delay slot.
- MEMORY:
  - LW/SW: data_req = 1, data_rd_wr = 1 (LW) / 0 (SW); data_addr and data_out held stable until data_ready.
  - Load data is captured on data_ready. Address bits [1:0] are ignored (word access only).
  - Non-memory instructions spend exactly one cycle in MEMORY with data_req = 0.
  - Timeout (DATA_TIMEOUT > 0): if data_ready has not arrived after DATA_TIMEOUT waiting cycles, set bus_error, drop data_req, and proceed. LW then writes 0.
- WRITEBACK:
  - Destination: rd for R-type, rt for ADDIU/SLTI/LW, r31 for JAL (value PC + 4 of the JAL). Writes to r0 are discarded.
  - PC <= next PC. Pulse retire for every decoded instruction, including NOP/illegal.
- Latency: 5 cycles per instruction with zero-wait memories; +1 per FETCH or MEMORY wait cycle.
- Reset mid-operation: aborts any stage immediately. Outstanding requests are dropped on the reset cycle, and no regfile write other than r29 occurs.
- Simultaneous instr_valid and reset: reset wins.
- data_ready outside MEMORY is ignored.
- instr_valid outside FETCH is ignored.

Optional Feature:
MIPS_RETIRE_CNT_EN
- Defined:
  - Adds output retire_count [31:0]; reset value 0.
  - Increments on every retire pulse and wraps 32'hFFFF_FFFF -> 0.
  - Adds output stall_count [31:0]: counts FETCH/MEMORY wait cycles, saturating at max.
- Undefined: neither port nor its counter logic exists; all other behaviour is identical.

Test Plan:
- Reset with SP_INIT = 32'h1000, RA_INIT = 32'h2000, PC_INIT = 32'h400 -> first instr_addr = 32'h400 with instr_req = 1 on cycle 2; r29 = 32'h1000, r31 = 32'h2000.
- ADDIU r8,r0,5; ADDIU r9,r0,-3; ADDU r10,r8,r9; SUBU r11,r9,r8; SLT r12,r9,r8 -> r10 = 2, r11 = 32'hFFFF_FFF8, r12 = 1; 5 retire pulses, each 5 cycles apart.
- SW r10,8(r29) with data_ready delayed 3 cycles, then LW r13,8(r29) -> write seen at addr 32'h1008 with data 2 and data_req held 4 cycles; r13 = 2; instruction latency 8 cycles.
- BEQ r0,r0,+2 at 32'h400 -> next instr_addr = 32'h40C. BNE r0,r0,+2 -> 32'h404. JAL to 32'h0040_0100 from 32'h404 -> r31 = 32'h408. JR r31 -> PC = 32'h408.
- Opcode 6'b111111 -> illegal_instr pulses once, no register change, PC advances by 4. LW with data_ready never asserted, DATA_TIMEOUT = 16 -> bus_error set after 16 wait cycles and rt = 0.
- Assert reset during MEMORY of an SW -> data_req low on the reset cycle, no store completes, and the FSM restarts at INIT_RA. With MIPS_RETIRE_CNT_EN defined, retire_count = 0 after the reset.
